// File: rtl/keypad_scan_if.sv
// Pin and status bundle of the keypad scanner: row/column lines towards the board,
// debounced key state towards the character and menu logic.
interface keypad_scan_if;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  mov;
    logic [15:0] key_state;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_press;

    modport master (
        input  key_row,
        output key_col, mov, key_state, key_code, key_valid, key_press
    );

    modport slave (
        output key_row,
        input  key_col, mov, key_state, key_code, key_valid, key_press
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: one-cold column drive, synchronized row
// capture, frame-level debounce and registered movement/key status outputs.
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 4
) (
    input  logic          sys_clk,
    input  logic          RST_N,
    keypad_scan_if.master bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEB_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEB_CNT);

    logic [3:0]       sync_q1;
    logic [3:0]       sync_q2;
    logic [DIV_W-1:0] div;
    logic [1:0]       col;
    logic [15:0]      frame;
    logic [15:0]      frame_full;
    logic [15:0]      candidate;
    logic [15:0]      key_state_q;
    logic [STB_W-1:0] stable;
    logic [STB_W-1:0] stable_inc;
    logic [3:0]       lowest_code;
    logic             slot_end;
    logic             frame_end;

    assign slot_end      = (div == DIV_LAST);
    assign frame_end     = slot_end && (col == 2'd3);
    assign stable_inc    = (stable == STB_MAX) ? STB_MAX : stable + 1'b1;
    assign bus.key_state = key_state_q;

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            sync_q1 <= 4'b1111;
            sync_q2 <= 4'b1111;
        end else begin
            sync_q1 <= bus.key_row;
            sync_q2 <= sync_q1;
        end
    end

    // Current column's rows merged into the buffer so the frame edge sees all 16 keys.
    always_comb begin
        frame_full = frame;
        for (int r = 0; r < 4; r++) begin
            frame_full[r*4 + int'(col)] = ~sync_q2[r];
        end
    end

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            div         <= '0;
            col         <= 2'd0;
            frame       <= 16'h0000;
            bus.key_col <= 4'b1110;
        end else if (slot_end) begin
            div         <= '0;
            col         <= col + 2'd1;
            frame       <= frame_full;
            bus.key_col <= ~(4'b0001 << (col + 2'd1));
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            candidate   <= 16'h0000;
            stable      <= '0;
            key_state_q <= 16'h0000;
        end else if (frame_end) begin
            if (frame_full == candidate) begin
                stable <= stable_inc;
                if (stable_inc == STB_MAX) begin
                    key_state_q <= candidate;
                end
            end else begin
                candidate <= frame_full;
                stable    <= STB_W'(1);
                if (DEB_CNT == 1) begin
                    key_state_q <= frame_full;
                end
            end
        end
    end

    always_comb begin
        lowest_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (key_state_q[i]) begin
                lowest_code = 4'(i);
            end
        end
    end

    // Opposing directions cancel; key_valid doubles as the previous-state flag for key_press.
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            bus.mov       <= 4'b0000;
            bus.key_code  <= 4'd0;
            bus.key_valid <= 1'b0;
            bus.key_press <= 1'b0;
        end else begin
            bus.mov       <= {key_state_q[1] & ~key_state_q[9],
                              key_state_q[9] & ~key_state_q[1],
                              key_state_q[4] & ~key_state_q[6],
                              key_state_q[6] & ~key_state_q[4]};
            bus.key_code  <= lowest_code;
            bus.key_valid <= |key_state_q;
            bus.key_press <= (|key_state_q) & ~bus.key_valid;
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: directed scenarios plus random key traffic,
// compared every cycle against a frame-level behavioural keypad model.
module tb_keypad_scan;
    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 3;
    localparam int FRAME    = 4 * SCAN_DIV;
    localparam int KEY_2 = 1;
    localparam int KEY_8 = 9;
    localparam int KEY_4 = 4;
    localparam int KEY_6 = 6;

    logic        sys_clk = 1'b0;
    logic        RST_N   = 1'b0;
    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int press_seen;
    int state_seen;

    logic [15:0] hist [FRAME];
    logic [15:0] m_cand, m_state, m_prev;
    int          m_stable;
    logic [3:0]  exp_mov, exp_code, exp_col;
    logic        exp_valid, exp_press;

    keypad_scan_if bus();

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
        .sys_clk(sys_clk),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // A row reads low while any pressed key in that row sits on the driven column.
    assign bus.key_row = {~|(pressed[15:12] & ~bus.key_col),
                          ~|(pressed[11:8]  & ~bus.key_col),
                          ~|(pressed[7:4]   & ~bus.key_col),
                          ~|(pressed[3:0]   & ~bus.key_col)};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ecount    = 0;
        m_cand    = 16'h0000;
        m_state   = 16'h0000;
        m_prev    = 16'h0000;
        m_stable  = 0;
        exp_mov   = 4'b0000;
        exp_code  = 4'd0;
        exp_valid = 1'b0;
        exp_press = 1'b0;
        exp_col   = 4'b1110;
    endtask

    task automatic checkOutput();
        check("key_col",   16'(bus.key_col),   16'(exp_col));
        check("key_state", bus.key_state,      m_state);
        check("mov",       16'(bus.mov),       16'(exp_mov));
        check("key_code",  16'(bus.key_code),  16'(exp_code));
        check("key_valid", 16'(bus.key_valid), 16'(exp_valid));
        check("key_press", 16'(bus.key_press), 16'(exp_press));
    endtask

    // Each key is seen as it stood two cycles before its column's capture edge.
    task automatic tick();
        logic [15:0] fr;
        int          slot;
        @(posedge sys_clk);
        hist[ecount % FRAME] = pressed;
        exp_mov   = {m_state[KEY_2] && !m_state[KEY_8], m_state[KEY_8] && !m_state[KEY_2],
                     m_state[KEY_4] && !m_state[KEY_6], m_state[KEY_6] && !m_state[KEY_4]};
        exp_code  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m_state[i]) begin
                exp_code = 4'(i);
                break;
            end
        end
        exp_valid = (m_state != 16'h0000);
        exp_press = (m_state != 16'h0000) && (m_prev == 16'h0000);
        m_prev    = m_state;
        if (ecount % FRAME == FRAME - 1) begin
            fr = 16'h0000;
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    fr[r*4 + c] = hist[c*SCAN_DIV + SCAN_DIV - 3][r*4 + c];
                end
            end
            if (fr == m_cand) begin
                m_stable = (m_stable + 1 > DEB_CNT) ? DEB_CNT : m_stable + 1;
            end else begin
                m_cand   = fr;
                m_stable = 1;
            end
            if (m_stable == DEB_CNT) m_state = m_cand;
        end
        slot    = ((ecount + 1) / SCAN_DIV) % 4;
        exp_col = ~(4'b0001 << slot);
        ecount++;
        #1;
        checkOutput();
    endtask

    task automatic run_to(input int n);
        while (ecount < n) tick();
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        pressed = keys;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst key_col",   16'(bus.key_col),   16'h000E);
        check("rst mov",       16'(bus.mov),       16'h0000);
        check("rst key_state", bus.key_state,      16'h0000);
        check("rst key_code",  16'(bus.key_code),  16'h0000);
        check("rst key_valid", 16'(bus.key_valid), 16'h0000);
        check("rst key_press", 16'(bus.key_press), 16'h0000);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        $display("[TB] start");

        // Idle scan, then hold "6" from the first frame boundary.
        do_reset();
        applyStimulus(16'h0000, 2 * FRAME);
        do_reset();
        pressed = 16'h0040;
        run_to(48);
        check("six key_state", bus.key_state, 16'h0040);
        check("six mov early", 16'(bus.mov), 16'h0000);
        run_to(49);
        check("six mov",       16'(bus.mov),       16'h0001);
        check("six key_code",  16'(bus.key_code),  16'h0006);
        check("six press",     16'(bus.key_press), 16'h0001);
        run_to(50);
        check("six press end", 16'(bus.key_press), 16'h0000);

        // "2" and "8" together cancel; releasing "8" leaves up without a new press.
        do_reset();
        pressed = 16'h0202;
        run_to(48);
        check("ud key_state", bus.key_state, 16'h0202);
        run_to(49);
        check("ud mov",   16'(bus.mov),       16'h0000);
        check("ud press", 16'(bus.key_press), 16'h0001);
        pressed    = 16'h0002;
        press_seen = 0;
        while (ecount < 97) begin
            tick();
            if (bus.key_press) press_seen++;
            if (ecount == 96) check("up mov early", 16'(bus.mov), 16'h0000);
        end
        check("up mov",        16'(bus.mov), 16'h0008);
        check("up no press",   16'(press_seen), 16'h0000);

        // Bounce on "4" toggling every 8 cycles, then a clean hold.
        do_reset();
        state_seen = 0;
        while (ecount < 68) begin
            pressed = (ecount >= 4 && ((ecount - 4) / 8) % 2 == 0) ? 16'h0010 : 16'h0000;
            tick();
            if (bus.key_state != 16'h0000) state_seen++;
        end
        check("bounce quiet", 16'(state_seen), 16'h0000);
        pressed = 16'h0010;
        run_to(128);
        check("left key_state", bus.key_state, 16'h0010);
        check("left mov early", 16'(bus.mov), 16'h0000);
        run_to(129);
        check("left mov", 16'(bus.mov), 16'h0002);

        // Up+right, then reset in the middle of a slot.
        do_reset();
        pressed = 16'h0042;
        run_to(49);
        check("ur mov",      16'(bus.mov),      16'h0009);
        check("ur key_code", 16'(bus.key_code), 16'h0001);
        run_to(50);
        do_reset();
        run_to(48);
        check("ur mov after reset", 16'(bus.mov), 16'h0000);
        run_to(49);
        check("ur mov relearned",   16'(bus.mov), 16'h0009);

        // Random key traffic with occasional short glitches.
        do_reset();
        for (int n = 0; n < 30; n++) begin
            logic [15:0] keys;
            keys = 16'h0000;
            if ($urandom_range(3, 0) != 0) begin
                for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
                    keys[$urandom_range(15, 0)] = 1'b1;
                end
            end
            applyStimulus(keys, int'($urandom_range(80, 1)));
            if ($urandom_range(1, 0) == 1) begin
                applyStimulus(keys ^ (16'h0001 << $urandom_range(15, 0)), int'($urandom_range(6, 1)));
                applyStimulus(keys, int'($urandom_range(40, 1)));
            end
        end
        applyStimulus(16'h0000, 4 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
